vcache_dma_arbiter: RTL and testbench

Shares one DMA channel (to the memory/DRAM controller) among `num_cache_p` vcache banks, each of which issues a DMA packet and then exchanges one cache block of data. A round-robin arbiter grants one bank at a time. A sequencer holds the grant until that bank's whole block transfer (fill or evict) has completed. The block sits between the vcache DMA ports and the single downstream DMA interface.

---
 rtl/vcache_dma_arbiter.sv | 155 +++++++++++++++
 tb/tb_vcache_dma_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcache_dma_arbiter.sv
// rtl/vcache_dma_arbiter.sv - round-robin sharing of one DMA channel among vcache banks
// The grant is held from packet issue until the full fill/evict block has been exchanged.
module vcache_dma_arbiter #(
    parameter int num_cache_p           = 4,
    parameter int addr_width_p          = 32,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int dma_pkt_width_lp      = 1 + addr_width_p
) (
    input  logic                                         clk_i,
    input  logic                                         reset_n_i,

    input  logic [num_cache_p-1:0][dma_pkt_width_lp-1:0] dma_pkt_i,
    input  logic [num_cache_p-1:0]                       dma_pkt_v_i,
    output logic [num_cache_p-1:0]                       dma_pkt_yumi_o,

    input  logic [num_cache_p-1:0][data_width_p-1:0]     dma_data_i,
    input  logic [num_cache_p-1:0]                       dma_data_v_i,
    output logic [num_cache_p-1:0]                       dma_data_yumi_o,

    output logic [data_width_p-1:0]                      dma_data_o,
    output logic [num_cache_p-1:0]                       dma_data_v_o,
    input  logic [num_cache_p-1:0]                       dma_data_ready_i,

    output logic [dma_pkt_width_lp-1:0]                  mem_dma_pkt_o,
    output logic                                         mem_dma_pkt_v_o,
    input  logic                                         mem_dma_pkt_yumi_i,

    input  logic [data_width_p-1:0]                      mem_dma_data_i,
    input  logic                                         mem_dma_data_v_i,
    output logic                                         mem_dma_data_ready_o,

    output logic [data_width_p-1:0]                      mem_dma_data_o,
    output logic                                         mem_dma_data_v_o,
    input  logic                                         mem_dma_data_yumi_i,

    output logic                                         busy_o
);

    localparam int gid_w_lp = (num_cache_p > 1) ? $clog2(num_cache_p) : 1;
    localparam int cnt_w_lp = $clog2(block_size_in_words_p + 1);

    localparam logic [gid_w_lp-1:0] last_id_lp     = gid_w_lp'(num_cache_p - 1);
    localparam logic [cnt_w_lp-1:0] block_words_lp = cnt_w_lp'(block_size_in_words_p);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PKT   = 2'd1;
    localparam logic [1:0] FILL  = 2'd2;
    localparam logic [1:0] EVICT = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [gid_w_lp-1:0] grant_id_q, grant_id_d;
    logic [gid_w_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [cnt_w_lp-1:0] word_cnt_q, word_cnt_d;

    logic                pick_found;
    logic [gid_w_lp-1:0] pick_id;

    logic in_pkt, in_fill, in_evict;
    logic sel_wnr, sel_evict_v, sel_fill_ready;
    logic pkt_hs, fill_hs, evict_hs, beat_hs, last_beat;

    // First requester at or after the rotating pointer wins.
    always_comb begin : rr_pick
        logic [gid_w_lp-1:0] idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int i = 0; i < num_cache_p; i++) begin
            idx = gid_w_lp'((int'(rr_ptr_q) + i) % num_cache_p);
            if (!pick_found && dma_pkt_v_i[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    // Gating with reset keeps every handshake quiet during the reset cycle itself.
    assign in_pkt   = reset_n_i && (state_q == PKT);
    assign in_fill  = reset_n_i && (state_q == FILL);
    assign in_evict = reset_n_i && (state_q == EVICT);

    assign sel_wnr        = dma_pkt_i[grant_id_q][dma_pkt_width_lp-1];
    assign sel_evict_v    = dma_data_v_i[grant_id_q];
    assign sel_fill_ready = dma_data_ready_i[grant_id_q];

    assign pkt_hs    = in_pkt & mem_dma_pkt_yumi_i;
    assign fill_hs   = in_fill & mem_dma_data_v_i & sel_fill_ready;
    assign evict_hs  = in_evict & sel_evict_v & mem_dma_data_yumi_i;
    assign beat_hs   = fill_hs | evict_hs;
    assign last_beat = (word_cnt_q + cnt_w_lp'(1)) == block_words_lp;

    assign mem_dma_pkt_o        = dma_pkt_i[grant_id_q];
    assign mem_dma_pkt_v_o      = in_pkt;
    assign mem_dma_data_ready_o = in_fill & sel_fill_ready;
    assign mem_dma_data_o       = dma_data_i[grant_id_q];
    assign mem_dma_data_v_o     = in_evict & sel_evict_v;
    assign dma_data_o           = mem_dma_data_i;
    assign busy_o               = reset_n_i && (state_q != IDLE);

    always_comb begin
        dma_pkt_yumi_o              = '0;
        dma_data_v_o                = '0;
        dma_data_yumi_o             = '0;
        dma_pkt_yumi_o[grant_id_q]  = pkt_hs;
        dma_data_v_o[grant_id_q]    = in_fill & mem_dma_data_v_i;
        dma_data_yumi_o[grant_id_q] = evict_hs;
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_id;
                    rr_ptr_d   = (pick_id == last_id_lp) ? '0 : pick_id + gid_w_lp'(1);
                    state_d    = PKT;
                end
            end
            PKT: begin
                if (pkt_hs) begin
                    word_cnt_d = '0;
                    state_d    = sel_wnr ? EVICT : FILL;
                end
            end
            FILL, EVICT: begin
                if (beat_hs) begin
                    word_cnt_d = word_cnt_q + cnt_w_lp'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_vcache_dma_arbiter.sv
// tb/tb_vcache_dma_arbiter.sv - scoreboard bench for vcache_dma_arbiter
module tb_vcache_dma_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int PW = AW + 1;

    localparam logic [1:0] K_PKT   = 2'd0;
    localparam logic [1:0] K_FILL  = 2'd1;
    localparam logic [1:0] K_EVICT = 2'd2;

    typedef struct packed {
        logic [1:0]    kind;
        logic [3:0]    bank;
        logic [PW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset_n;
    logic [N-1:0][PW-1:0]   dma_pkt_i;
    logic [N-1:0]           dma_pkt_v_i;
    logic [N-1:0]           dma_pkt_yumi_o;
    logic [N-1:0][DW-1:0]   dma_data_i;
    logic [N-1:0]           dma_data_v_i;
    logic [N-1:0]           dma_data_yumi_o;
    logic [DW-1:0]          dma_data_o;
    logic [N-1:0]           dma_data_v_o;
    logic [N-1:0]           dma_data_ready_i;
    logic [PW-1:0]          mem_dma_pkt_o;
    logic                   mem_dma_pkt_v_o;
    logic                   mem_dma_pkt_yumi_i;
    logic [DW-1:0]          mem_dma_data_i;
    logic                   mem_dma_data_v_i;
    logic                   mem_dma_data_ready_o;
    logic [DW-1:0]          mem_dma_data_o;
    logic                   mem_dma_data_v_o;
    logic                   mem_dma_data_yumi_i;
    logic                   busy_o;

    vcache_dma_arbiter #(
        .num_cache_p          (N),
        .addr_width_p         (AW),
        .data_width_p         (DW),
        .block_size_in_words_p(BW)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .dma_pkt_i           (dma_pkt_i),
        .dma_pkt_v_i         (dma_pkt_v_i),
        .dma_pkt_yumi_o      (dma_pkt_yumi_o),
        .dma_data_i          (dma_data_i),
        .dma_data_v_i        (dma_data_v_i),
        .dma_data_yumi_o     (dma_data_yumi_o),
        .dma_data_o          (dma_data_o),
        .dma_data_v_o        (dma_data_v_o),
        .dma_data_ready_i    (dma_data_ready_i),
        .mem_dma_pkt_o       (mem_dma_pkt_o),
        .mem_dma_pkt_v_o     (mem_dma_pkt_v_o),
        .mem_dma_pkt_yumi_i  (mem_dma_pkt_yumi_i),
        .mem_dma_data_i      (mem_dma_data_i),
        .mem_dma_data_v_i    (mem_dma_data_v_i),
        .mem_dma_data_ready_o(mem_dma_data_ready_o),
        .mem_dma_data_o      (mem_dma_data_o),
        .mem_dma_data_v_o    (mem_dma_data_v_o),
        .mem_dma_data_yumi_i (mem_dma_data_yumi_i),
        .busy_o              (busy_o)
    );

    ev_t           exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fill_base [N];
    logic [DW-1:0] ev_base   [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] idx_of(input logic [N-1:0] v);
        if ($countones(v) != 1) return 4'hF;
        for (int i = 0; i < N; i++) if (v[i]) return 4'(i);
        return 4'hF;
    endfunction

    function automatic ev_t mk(input logic [1:0] k, input int b, input logic [PW-1:0] d);
        ev_t e;
        e.kind = k;
        e.bank = 4'(b);
        e.data = d;
        return e;
    endfunction

    task automatic observe(input ev_t o);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected: got kind=%0d bank=%0d data=%0h, expected nothing",
                     o.kind, o.bank, o.data);
        end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL scoreboard: got kind=%0d bank=%0d data=%0h, expected kind=%0d bank=%0d data=%0h",
                         o.kind, o.bank, o.data, e.kind, e.bank, e.data);
            end
        end
    endtask

    // Monitor: every completed handshake on the DUT is matched against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (mem_dma_pkt_v_o && mem_dma_pkt_yumi_i)
                    observe(mk(K_PKT, int'(idx_of(dma_pkt_yumi_o)), mem_dma_pkt_o));
                if (mem_dma_data_ready_o && mem_dma_data_v_i)
                    observe(mk(K_FILL, int'(idx_of(dma_data_v_o)), {1'b0, dma_data_o}));
                if (mem_dma_data_v_o && mem_dma_data_yumi_i)
                    observe(mk(K_EVICT, int'(idx_of(dma_data_yumi_o)), {1'b0, mem_dma_data_o}));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input int b, input logic wnr, input logic [AW-1:0] addr, input int beats);
        exp_q.push_back(mk(K_PKT, b, {wnr, addr}));
        for (int i = 0; i < beats; i++)
            exp_q.push_back(mk(wnr ? K_EVICT : K_FILL, b,
                               {1'b0, (wnr ? ev_base[b] : fill_base[b]) + 32'(i)}));
    endtask

    function automatic logic [6:0] all_hs_outs();
        return {mem_dma_pkt_v_o, mem_dma_data_ready_o, mem_dma_data_v_o, |dma_data_v_o,
                |dma_pkt_yumi_o, |dma_data_yumi_o, busy_o};
    endfunction

    // Plays downstream and the granted bank for one transaction; entered just after a posedge.
    task automatic serve_one(input int pkt_stall, input int ready_gap, input bit alt_yumi,
                             input int abort_after, output int lat);
        int  b, k, l, pulses, gap, guard;
        bit  wnr, aborted;
        mem_dma_pkt_yumi_i = (pkt_stall == 0);
        for (l = 0; l < 20; l++) begin
            @(negedge clk);
            if (mem_dma_pkt_v_o) break;
            chk("idle_no_pkt_yumi", {28'd0, dma_pkt_yumi_o}, 0);
        end
        lat = l;
        if (l == 20) begin
            chk("pkt_timeout", 1, 0);
            mem_dma_pkt_yumi_i = 1'b0;
            return;
        end
        for (int s = 0; s < pkt_stall; s++) begin
            chk("pkt_stall_yumi", {28'd0, dma_pkt_yumi_o}, 0);
            chk("pkt_stall_v", {63'd0, mem_dma_pkt_v_o}, 1);
            tick();
            if (s == pkt_stall - 1) mem_dma_pkt_yumi_i = 1'b1;
            @(negedge clk);
        end
        b   = int'(idx_of(dma_pkt_yumi_o));
        wnr = mem_dma_pkt_o[PW-1];
        tick();
        mem_dma_pkt_yumi_i = 1'b0;
        if (b >= N) begin
            chk("pkt_yumi_onehot", 64'(b), 0);
            return;
        end
        dma_pkt_v_i[b] = 1'b0;
        k = 0; pulses = 0; gap = ready_gap; aborted = 1'b0;
        for (guard = 0; guard < 200 && k < BW && !aborted; guard++) begin
            if (!wnr) begin
                mem_dma_data_v_i    = 1'b1;
                mem_dma_data_i      = fill_base[b] + 32'(k);
                dma_data_ready_i[b] = !(k == 3 && gap > 0);
            end else begin
                dma_data_v_i[b]     = 1'b1;
                dma_data_i[b]       = ev_base[b] + 32'(k);
                mem_dma_data_yumi_i = alt_yumi ? (guard % 2 == 1) : 1'b1;
            end
            @(negedge clk);
            if (!wnr) begin
                if (!dma_data_ready_i[b]) begin
                    chk("stall_fill_ready", {63'd0, mem_dma_data_ready_o}, 0);
                    chk("stall_busy", {63'd0, busy_o}, 1);
                    gap--;
                end else if (mem_dma_data_ready_o) begin
                    k++;
                end
            end else begin
                if (dma_data_yumi_o[b]) pulses++;
                if (mem_dma_data_v_o && mem_dma_data_yumi_i) k++;
            end
            if (abort_after != 0 && k == abort_after) aborted = 1'b1;
            tick();
        end
        if (aborted) begin
            reset_n = 1'b0;
            @(negedge clk);
            chk("reset_cycle_outputs", {57'd0, all_hs_outs()}, 0);
            tick();
            reset_n = 1'b1;
            @(negedge clk);
            chk("post_reset_outputs", {57'd0, all_hs_outs()}, 0);
            tick();
            mem_dma_data_v_i = 1'b0;
            return;
        end
        mem_dma_data_v_i    = 1'b0;
        mem_dma_data_yumi_i = 1'b0;
        dma_data_v_i[b]     = 1'b0;
        dma_data_ready_i    = '1;
        chk("beats_done", 64'(k), BW);
        if (wnr) chk("evict_yumi_pulses", 64'(pulses), BW);
        @(negedge clk);
        chk("turnaround_busy", {63'd0, busy_o}, 0);
        chk("turnaround_no_pkt", {63'd0, mem_dma_pkt_v_o}, 0);
        tick();
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int lat;
        reset_n             = 1'b0;
        dma_pkt_i           = '0;
        dma_pkt_v_i         = '0;
        dma_data_i          = '0;
        dma_data_v_i        = '0;
        dma_data_ready_i    = '1;
        mem_dma_pkt_yumi_i  = 1'b0;
        mem_dma_data_i      = '0;
        mem_dma_data_v_i    = 1'b0;
        mem_dma_data_yumi_i = 1'b0;
        fill_base = '{32'h0000_10F0, 32'h0000_20F0, 32'h0000_00A0, 32'h0000_40F0};
        ev_base   = '{32'h0E00_0000, 32'hE100_0000, 32'h0E20_0000, 32'h0E30_0000};

        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs", {57'd0, all_hs_outs()}, 0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {57'd0, all_hs_outs()}, 0);
        tick();

        // Single read from bank 2
        push_txn(2, 1'b0, 32'h0000_1000, BW);
        dma_pkt_i[2]   = {1'b0, 32'h0000_1000};
        dma_pkt_v_i[2] = 1'b1;
        serve_one(0, 0, 1'b0, 0, lat);
        chk("request_latency", 64'(lat), 1);

        // Round robin from reset, bank 0 re-requests after its first grant
        do_reset(2);
        for (int b = 0; b < N; b++) begin
            dma_pkt_i[b] = {1'b0, 32'h0000_2000 + 32'(b * 'h40)};
            push_txn(b, 1'b0, 32'h0000_2000 + 32'(b * 'h40), BW);
        end
        push_txn(0, 1'b0, 32'h0000_2400, BW);
        dma_pkt_v_i = '1;
        serve_one(0, 0, 1'b0, 0, lat);
        dma_pkt_i[0]   = {1'b0, 32'h0000_2400};
        dma_pkt_v_i[0] = 1'b1;
        for (int t = 0; t < N; t++) serve_one(0, 0, 1'b0, 0, lat);

        // Evict from bank 1 with downstream yumi every other cycle
        push_txn(1, 1'b1, 32'h0000_3000, BW);
        dma_pkt_i[1]   = {1'b1, 32'h0000_3000};
        dma_pkt_v_i[1] = 1'b1;
        serve_one(0, 0, 1'b1, 0, lat);

        // Packet stall of 5 cycles, then fill ready dropped for 3 cycles at beat 3
        push_txn(3, 1'b0, 32'h0000_4000, BW);
        dma_pkt_i[3]   = {1'b0, 32'h0000_4000};
        dma_pkt_v_i[3] = 1'b1;
        serve_one(5, 3, 1'b0, 0, lat);

        // Reset after beat 3 of a fill, then a fresh full fill
        push_txn(0, 1'b0, 32'h0000_5000, 3);
        dma_pkt_i[0]   = {1'b0, 32'h0000_5000};
        dma_pkt_v_i[0] = 1'b1;
        serve_one(0, 0, 1'b0, 3, lat);
        push_txn(0, 1'b0, 32'h0000_5100, BW);
        dma_pkt_i[0]   = {1'b0, 32'h0000_5100};
        dma_pkt_v_i[0] = 1'b1;
        serve_one(0, 0, 1'b0, 0, lat);

        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
